// File: rtl/branch_sequencer.sv
// PC owner and control-flow redirect sequencer: EX branch resolution, ID jumps,
// multi-cycle wrong-path flush and wrap-around branch statistics.
module branch_sequencer #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      FLUSH_DEPTH = 2,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Branche,
    input  logic             Branchn,
    input  logic             Zero,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PC,
    output logic             PCSrc,
    output logic             Flush,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt
);
    localparam int unsigned      FC_W  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [FC_W-1:0]   fcnt, fcnt_nxt;
    logic [WIDTH-1:0]  pc_nxt;
    logic [CNT_W-1:0]  bcnt_nxt, tcnt_nxt;
    logic              taken, is_branch, accept;

    // beq+bne together collapses to an unconditional taken branch
    assign taken     = (Branche & Zero) | (Branchn & ~Zero);
    assign is_branch = Branche | Branchn;
    assign accept    = (state == RUN) & ~Stall;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state logic: a taken branch flushes FLUSH_DEPTH cycles, a jump one cycle
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            RUN: begin
                if (accept) begin
                    if (taken) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FC_W'(FLUSH_DEPTH - 1);
                    end else if (Jump) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = '0;
                    end
                end
            end
            FLUSH: begin
                if (!Stall) begin
                    if (fcnt == '0) state_nxt = RUN;
                    else            fcnt_nxt  = fcnt - FC_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Output logic: redirect select, next PC and statistics
    always_comb begin
        pc_nxt   = PC;
        bcnt_nxt = BranchCnt;
        tcnt_nxt = TakenCnt;
        PCSrc    = accept & taken & ~reset;
        if (accept) begin
            if (is_branch) bcnt_nxt = BranchCnt + CNT_W'(1);
            if (taken) begin
                pc_nxt   = BranchTarget & ALIGN;
                tcnt_nxt = TakenCnt + CNT_W'(1);
            end else if (Jump) begin
                pc_nxt = JumpTarget & ALIGN;
            end else begin
                pc_nxt = PC + WIDTH'(4);
            end
        end else if ((state == FLUSH) && !Stall) begin
            pc_nxt = PC + WIDTH'(4);
        end
    end

    // Registered outputs; Flush mirrors the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC        <= RESET_PC & ALIGN;
            Flush     <= 1'b0;
            BranchCnt <= '0;
            TakenCnt  <= '0;
        end else begin
            PC        <= pc_nxt;
            Flush     <= (state_nxt == FLUSH);
            BranchCnt <= bcnt_nxt;
            TakenCnt  <= tcnt_nxt;
        end
    end
endmodule
